lsu_strobe_unit: RTL and testbench

- Parametrised successor of the pipeline's one-cycle load/store unit.
- Adds a valid/ready request handshake and a configurable local data memory (words, address width).
- Provides true byte-strobe stores with no read-modify-write, a configurable load latency, and a misalignment error response.
- Sits between EX (address operands) and WB (load data); drives the stall line to the controller.

---
 rtl/lsu_strobe_unit_pkg.sv | 30 +++
 rtl/lsu_strobe_unit_lane_align.sv | 46 ++++
 rtl/lsu_strobe_unit.sv | 145 ++++++++++++++
 tb/tb_lsu_strobe_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_strobe_unit_pkg.sv
// rtl/lsu_strobe_unit_pkg.sv - shared encodings and alignment check for the strobe LSU
package lsu_strobe_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_RSP  = 3'd2,
        ST_RSP  = 3'd3,
        ERR     = 3'd4
    } state_e;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        is_misaligned = bad;
    endfunction

endpackage

// File: rtl/lsu_strobe_unit_lane_align.sv
// rtl/lsu_strobe_unit_lane_align.sv - store strobe/replicate and load extract/extend
module lsu_lane_align
    import lsu_strobe_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    size_e       size_s;
    logic [31:0] shifted;

    assign size_s  = size_e'(size);
    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        strb      = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        case (size_s)
            SZ_B: begin
                strb      = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                strb      = 4'b0011 << lane;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                strb      = 4'b1111;
                rdata_ext = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_strobe_unit.sv
// rtl/lsu_strobe_unit.sv - handshaked load/store unit with byte strobes and local memory
module lsu_strobe_unit
    import lsu_strobe_unit_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LOAD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_off,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              hold_o
);

    localparam int IDX = $clog2(MEM_WORDS);
    localparam logic [1:0] CNT_LAST = 2'(LOAD_LAT >= 2 ? LOAD_LAT - 2 : 0);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;

    logic [31:0] mem_q [MEM_WORDS];

    logic [ADDR_W-1:0] ea;
    logic [IDX-1:0]    idx;
    logic [1:0]        lane;
    logic              fire;
    logic              bad;
    logic              wr_en;
    logic [3:0]        strb;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              unused_ea;

    assign ea        = req_base + req_off;
    assign idx       = ea[IDX+1:2];
    assign lane      = ea[1:0];
    assign unused_ea = ^ea[ADDR_W-1:IDX+2];

    assign req_ready = ~rst & (state_q == IDLE);
    assign fire      = req_valid & req_ready;
    assign bad       = is_misaligned(size_e'(req_size), lane);
    assign wr_en     = fire & req_we & ~bad;

    lsu_lane_align u_align (
        .size        (req_size),
        .lane        (lane),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (mem_q[idx]),
        .strb        (strb),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    // Only one request is outstanding, so the addressed word cannot change before
    // the response: a single capture register stands in for the whole latency pipe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        hold_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    hold_o = 1'b1;
                    if (bad) begin
                        state_d = ERR;
                    end else if (req_we) begin
                        state_d = ST_RSP;
                    end else begin
                        data_d  = rdata_ext;
                        cnt_d   = 2'd0;
                        state_d = (LOAD_LAT == 1) ? LD_RSP : LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                hold_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = LD_RSP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            LD_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = data_q;
                state_d   = IDLE;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            rsp_valid = 1'b0;
            rsp_rdata = 32'h0;
            rsp_err   = 1'b0;
            hold_o    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_strobe_unit.sv
// tb/tb_lsu_strobe_unit.sv - randomized self-checking bench with a byte-addressed memory model
module tb_lsu_strobe_unit;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int LOAD_LAT  = 3;
    localparam int MEM_BYTES = MEM_WORDS * 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_base = '0;
    logic [ADDR_W-1:0] req_off = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              hold_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mref [MEM_BYTES];

    lsu_strobe_unit #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS),
        .LOAD_LAT  (LOAD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_base     (req_base),
        .req_off      (req_off),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .hold_o       (hold_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [31:0] ea, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        return (ea % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] ea, input logic [1:0] sz,
                                               input logic uns);
        int n = nbytes(sz);
        int a = int'(ea % MEM_BYTES);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mref[a+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] ea, input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        int a = int'(ea % MEM_BYTES);
        for (int i = 0; i < n; i++) mref[a+i] = 8'(wd >> (8*i));
    endtask

    // One full transaction: accept cycle, wait cycles, response cycle, return to idle.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] ea = base + off;
        logic        err = model_err(ea, sz);
        int          lat = (we || err) ? 1 : LOAD_LAT;
        logic [31:0] exp = (we || err) ? 32'h0 : model_load(ea, sz, uns);
        got = 32'hx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_base = base; req_off = off; req_wdata = wd;
        #1;
        check("accept_ready", 32'(req_ready), 32'd1);
        check("accept_hold", 32'(hold_o), 32'd1);
        @(posedge clk);
        if (we && !err) model_store(ea, sz, wd);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (k < lat) begin
                check("wait_hold", 32'(hold_o), 32'd1);
                check("wait_valid", 32'(rsp_valid), 32'd0);
                check("wait_ready", 32'(req_ready), 32'd0);
            end else if (k == lat) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_err", 32'(rsp_err), 32'(err));
                check("rsp_rdata", rsp_rdata, exp);
                check("rsp_hold", 32'(hold_o), 32'd0);
                check("rsp_ready", 32'(req_ready), 32'd0);
                got = rsp_rdata;
            end else begin
                check("idle_ready", 32'(req_ready), 32'd1);
                check("idle_valid", 32'(rsp_valid), 32'd0);
                check("idle_rdata", rsp_rdata, 32'h0);
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] ea, base;
        logic [1:0]  sz;

        for (int i = 0; i < MEM_BYTES; i++) mref[i] = 8'h0;

        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_hold", 32'(hold_o), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Initialise the low 64 bytes so every later load has defined data.
        for (int w = 0; w < 16; w++) do_req(1'b1, 2'd2, 1'b0, 32'(w*4), 32'h0, $urandom, got);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, got);
        check("ld_word_dead", got, 32'hDEADBEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000080, got);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0, got);
        check("ld_byte_signed", got, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h3, 32'h0, got);
        check("ld_byte_unsigned", got, 32'h00000080);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, got);
        check("ld_word_lane3", got, 32'h80ADBEEF);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, got);
        do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h0, 32'hFFFF, got);
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 32'h12345678, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, got);
        check("err_no_write", got, 32'h80ADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h12345678, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h0, got);
        check("alias_1004", got, 32'h12345678);
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0, got);
        check("alias_4", got, 32'h12345678);

        // Back-to-back: second request held on req_valid is taken after the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_base = 32'h10; req_off = 32'h0;
        #1;
        check("b2b_ready_T", 32'(req_ready), 32'd1);
        for (int k = 1; k <= LOAD_LAT; k++) begin
            @(negedge clk);
            #1;
            check("b2b_ready_busy", 32'(req_ready), 32'd0);
            check("b2b_hold", 32'(hold_o), 32'(k < LOAD_LAT));
            check("b2b_valid", 32'(rsp_valid), 32'(k == LOAD_LAT));
        end
        @(negedge clk);
        #1;
        check("b2b_ready_again", 32'(req_ready), 32'd1);
        check("b2b_hold_again", 32'(hold_o), 32'd1);
        for (int k = 1; k <= LOAD_LAT + 1; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check("b2b2_valid", 32'(rsp_valid), 32'(k == LOAD_LAT));
            if (k == LOAD_LAT) check("b2b2_rdata", rsp_rdata, 32'h80ADBEEF);
        end

        // Store attempted while reset is held must not write.
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, got);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_base = 32'h20; req_off = 32'h0; req_wdata = 32'h11111111;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, got);
        check("rst_store_nowrite", got, 32'hAAAA5555);

        // Load discarded by reset one cycle after accept.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_base = 32'h20; req_off = 32'h0;
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("mid_rst_hold", 32'(hold_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_hold2", 32'(hold_o), 32'd0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        for (int k = 0; k < LOAD_LAT; k++) begin
            @(negedge clk);
            #1;
            check("mid_rst_novalid", 32'(rsp_valid), 32'd0);
        end

        for (int i = 0; i < 150; i++) begin
            sz   = 2'($urandom_range(0, 3));
            ea   = {$urandom_range(0, 32'hFFFFF), 6'd0, 6'($urandom_range(0, 63))};
            base = $urandom;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   base, ea - base, $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
